iltype_instr_gen: RTL and testbench

- Synthesizable instruction-stream source that drives the imem response port of the sodor5 verification wrapper (model plus RTL core under lockstep comparison).
- Emits a pseudo-random mix of RV32I I-type ALU instructions (opcode 0010011) and byte loads (opcode 0000011), constrained to legal encodings.
- Frames the stream with a NOP warm-up and an instruction budget.
- Uses a valid/ready handshake so the stream can be stalled and replayed deterministically from a seed.

---
 rtl/iltype_instr_gen.sv | 82 ++++++++
 tb/tb_iltype_instr_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/iltype_instr_gen.sv
// iltype_instr_gen: seeded RV32I I-type ALU / byte-load stream with NOP warm-up and budget.
// Optional ILGEN_LOAD_ADDR_MASK_EN limits load offsets to a 256-byte window.
module iltype_instr_gen #(
  parameter logic [63:0] SEED       = 64'h0000_0000_0000_009D,
  parameter int          NOP_CYCLES = 3,
  parameter int          NUM_INSTRS = 100,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             instr_ready,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic             is_load,
  output logic [CNT_W-1:0] issued_cnt,
  output logic             done
);
  localparam logic [31:0]      NOP       = 32'h0000_0013;
  localparam logic [63:0]      SEED_I    = (SEED == 64'd0) ? 64'd1 : SEED;
  localparam logic [63:0]      TAPS      = 64'hD800_0000_0000_0000;
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(NOP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(NUM_INSTRS - 1);
  typedef enum logic [1:0] {WARMUP, RUN, DONE} state_t;
  state_t           state;
  logic [CNT_W-1:0] warm_cnt;
  logic [63:0]      lfsr;
  logic             cur_rand;
  logic [11:0]      imm, imm_l;
  logic [2:0]       f3, f3_l;
  logic [31:0]      rand_word;
  logic             rand_load, xfer, load, last, gen_rand;
  assign f3 = lfsr[24:22];
  assign imm = (f3 == 3'b101) ? (lfsr[11:0] & 12'h41F) :
               (f3 == 3'b001) ? (lfsr[11:0] & 12'h01F) : lfsr[11:0];
`ifdef ILGEN_LOAD_ADDR_MASK_EN
  assign imm_l = lfsr[39:28] & 12'h0FF;
`else
  assign imm_l = lfsr[39:28];
`endif
  assign f3_l      = lfsr[27:25] & 3'b100;
  assign rand_load = !lfsr[40];
  assign rand_word = rand_load ? {imm_l, lfsr[16:12], f3_l, lfsr[21:17], 7'b0000011}
                               : {imm, lfsr[16:12], f3, lfsr[21:17], 7'b0010011};
  assign xfer = instr_valid && instr_ready;
  assign load = (!instr_valid || xfer) && en;
  // The final budgeted transfer reloads a NOP so nothing past the budget is ever generated.
  assign last = xfer && cur_rand && (NUM_INSTRS != 0) && (issued_cnt == LAST);
  assign gen_rand = load && !last && (state == RUN || (state == WARMUP && NOP_CYCLES == 0));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr       <= NOP;
      instr_valid <= 1'b0;
      is_load     <= 1'b0;
      issued_cnt  <= '0;
      done        <= 1'b0;
      state       <= WARMUP;
      warm_cnt    <= '0;
      lfsr        <= SEED_I;
      cur_rand    <= 1'b0;
    end else begin
      if (xfer && cur_rand && issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
      if (last) begin
        state <= DONE;
        done  <= 1'b1;
      end
      if (load) begin
        instr_valid <= 1'b1;
        instr       <= gen_rand ? rand_word : NOP;
        is_load     <= gen_rand && rand_load;
        cur_rand    <= gen_rand;
      end else if (xfer) begin
        instr_valid <= 1'b0;
      end
      if (gen_rand) lfsr <= {1'b0, lfsr[63:1]} ^ (lfsr[0] ? TAPS : 64'd0);
      if (load && state == WARMUP) begin
        if (NOP_CYCLES == 0 || warm_cnt == WARM_LAST) state <= RUN;
        else warm_cnt <= warm_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_iltype_instr_gen.sv
// tb_iltype_instr_gen: scoreboard bench for iltype_instr_gen (unlimited-budget and 4-instruction instances).
module tb_iltype_instr_gen;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct packed {logic [31:0] w; logic ld; logic rnd;} exp_t;
  logic clk = 1'b0, reset_n = 1'b1, en = 1'b0, instr_ready = 1'b0;
  logic v1, l1, d1, v2, l2, d2;
  logic [31:0] i1, i2;
  logic [15:0] c1, c2;
  exp_t q1[$], q2[$];
  int n_checks = 0, n_pass = 0, x1 = 0, r1 = 0, r2 = 0;

  initial forever #5 clk = ~clk;

  iltype_instr_gen #(.SEED(64'h9D), .NOP_CYCLES(3), .NUM_INSTRS(0), .CNT_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .instr_ready(instr_ready), .instr_valid(v1),
    .instr(i1), .is_load(l1), .issued_cnt(c1), .done(d1));
  iltype_instr_gen #(.SEED(64'h0), .NOP_CYCLES(3), .NUM_INSTRS(4), .CNT_W(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .en(en), .instr_ready(instr_ready), .instr_valid(v2),
    .instr(i2), .is_load(l2), .issued_cnt(c2), .done(d2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // Reference LFSR: shift right, feedback of bit 0 into the x^63/x^61/x^60 terms and the top bit.
  function automatic logic [63:0] step(input logic [63:0] l);
    logic fb;
    fb = l[0];
    l = l >> 1;
    if (fb) begin
      l[63] = ~l[63];
      l[62] = ~l[62];
      l[60] = ~l[60];
      l[59] = ~l[59];
    end
    return l;
  endfunction

  function automatic exp_t gen(input logic [63:0] l);
    logic [11:0] imm, imml;
    logic [2:0] f3;
    exp_t e;
    imm = l[11:0];
    f3 = l[24:22];
    imml = l[39:28];
`ifdef ILGEN_LOAD_ADDR_MASK_EN
    imml[11:8] = 4'h0;
`endif
    if (f3 == 3'd5) imm = {1'b0, imm[10], 5'b0, imm[4:0]};
    if (f3 == 3'd1) imm = {7'b0, imm[4:0]};
    e.rnd = 1'b1;
    e.ld = !l[40];
    e.w = l[40] ? {imm, l[16:12], f3, l[21:17], 7'h13}
                : {imml, l[16:12], l[27], 2'b00, l[21:17], 7'h03};
    return e;
  endfunction

  task automatic load_expect(input int which, input int n);
    logic [63:0] l;
    exp_t e;
    l = (which == 1) ? 64'h9D : 64'h1;
    e.w = NOP; e.ld = 1'b0; e.rnd = 1'b0;
    repeat (3) if (which == 1) q1.push_back(e); else q2.push_back(e);
    for (int i = 0; i < n; i++) begin
      e = gen(l);
      if (which == 1) q1.push_back(e); else q2.push_back(e);
      l = step(l);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && v1 && instr_ready) begin
      if (q1.size() == 0) begin
        n_checks++;
        $display("FAIL sb1_empty: got word %h with no expectation", i1);
      end else begin
        e = q1.pop_front();
        chk("sb1_instr", i1, e.w);
        chk("sb1_load", l1, e.ld);
        chk("sb1_cnt", c1, r1);
        if (e.rnd) r1++;
      end
      if (x1 == 3) chk("first_rand_word", i1, 32'h0000_0003);
      chk("opcode_legal", i1[6:0] == 7'h13 || i1[6:0] == 7'h03, 1);
      chk("is_load_flag", l1, i1[6:0] == 7'h03);
      if (i1[6:0] == 7'h03) chk("load_f3", i1[14:12] == 3'd0 || i1[14:12] == 3'd4, 1);
      if (i1[6:0] == 7'h13 && i1[14:12] == 3'd5) chk("sr_imm", i1[31:25] == 7'h00 || i1[31:25] == 7'h20, 1);
      if (i1[6:0] == 7'h13 && i1[14:12] == 3'd1) chk("sll_imm", i1[31:25], 0);
`ifdef ILGEN_LOAD_ADDR_MASK_EN
      if (i1[6:0] == 7'h03) chk("load_mask", i1[31:28], 0);
`endif
      x1++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      chk("d2_done", d2, r2 == 4);
      chk("d2_cnt", c2, r2);
      if (v2 && instr_ready) begin
        e.w = NOP; e.ld = 1'b0; e.rnd = 1'b0;
        if (q2.size() != 0) e = q2.pop_front();
        chk("sb2_instr", i2, e.w);
        chk("sb2_load", l2, e.ld);
        if (e.rnd) r2++;
      end
    end
  end

  task automatic wait_x1(input int n);
    int k;
    for (k = 0; k < 40000 && x1 < n; k++) begin
      @(posedge clk);
      #1;
      if (n > 100) instr_ready = (k % 7 != 3);
    end
    if (x1 < n) begin
      n_checks++;
      $display("FAIL timeout: got %0d transfers want %0d", x1, n);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_valid"}, {v2, v1}, 0);
    chk({nm, "_instr"}, i1, NOP);
    chk({nm, "_load"}, l1, 0);
    chk({nm, "_cnt"}, {c2, c1}, 0);
    chk({nm, "_done"}, {d2, d1}, 0);
  endtask

  initial begin
    logic [31:0] held;
    #1 reset_n = 1'b0;
    #1 chk_reset("reset");
    load_expect(1, 200);
    load_expect(2, 4);
    @(posedge clk);
    #1 reset_n = 1'b1; en = 1'b1; instr_ready = 1'b1;
    wait_x1(4);
    chk("cnt_after_first_rand", c1, 1);
    en = 1'b0;
    @(posedge clk);
    #1 chk("en_low_bubble", v1, 0);
    en = 1'b1;
    wait_x1(20);
    instr_ready = 1'b0;
    held = i1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", i1, held);
      chk("stall_valid", v1, 1);
    end
    @(posedge clk);
    #1 instr_ready = 1'b1;
    wait_x1(40);
    #2 reset_n = 1'b0;
    #1 chk_reset("midrun_reset");
    q1.delete(); q2.delete();
    x1 = 0; r1 = 0; r2 = 0;
    load_expect(1, 10100);
    load_expect(2, 4);
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_x1(10003);
    chk("d2_final_cnt", c2, 4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
